// File: rtl/rx_source_select_pkg.sv
// -----------------------------------------------------------------------------
// rx_source_pkg
//   Shared definitions for the receive-path source selector: source encodings,
//   MODE register bit positions, settings-bus register offsets, the burst FSM
//   state encoding and the PRBS15 seed base / next-state function.
// -----------------------------------------------------------------------------
package rx_source_pkg;

  // Sample source selected by MODE[2:0]. Codes 5..7 are not listed and fall
  // back to DDC through decode_src().
  typedef enum logic [2:0] {
    SRC_DDC   = 3'd0,
    SRC_CNT   = 3'd1,
    SRC_ADC   = 3'd2,
    SRC_CONST = 3'd3,
    SRC_PRBS  = 3'd4
  } src_e;

  // MODE register layout.
  localparam int MODE_SRC_LSB   = 0;
  localparam int MODE_SRC_W     = 3;
  localparam int MODE_BURST_BIT = 3;
  localparam int MODE_ARM_BIT   = 4;
  localparam int MODE_STORED_W  = 4;  // arm is a pulse and is never stored

  // Register offsets relative to the block base address.
  localparam logic [6:0] OFF_MODE  = 7'd0;
  localparam logic [6:0] OFF_LEN   = 7'd1;
  localparam logic [6:0] OFF_CONST = 7'd2;

  // Burst-capture FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } burst_state_e;

  // Channel k's LFSR seeds to PRBS_SEED_BASE + k.
  localparam logic [14:0] PRBS_SEED_BASE = 15'd1;

  // Map the raw 3-bit source field onto a legal source.
  function automatic src_e decode_src(input logic [2:0] field);
    case (field)
      3'd1:    return SRC_CNT;
      3'd2:    return SRC_ADC;
      3'd3:    return SRC_CONST;
      3'd4:    return SRC_PRBS;
      default: return SRC_DDC;
    endcase
  endfunction

  // x^15 + x^14 + 1, Fibonacci form: shift left, feedback enters at bit 0.
  function automatic logic [14:0] prbs15_next(input logic [14:0] s);
    return {s[13:0], s[14] ^ s[13]};
  endfunction

endpackage

// File: rtl/rx_source_select_if.sv
// -----------------------------------------------------------------------------
// rx_source_select_if
//   Bundles the settings bus, the incoming sample stream and the selected
//   output stream of rx_source_select.
//   Settings : serial_strobe, serial_addr[6:0], serial_data[31:0]
//   Inputs   : enable, in_strobe, ddc_in[NCHAN*16], adc_in[NCHAN*ADC_W]
//   Outputs  : ch_out[NCHAN*16], out_strobe, burst_active, burst_done,
//              sample_count[15:0]
//   modport master : the environment (drives inputs, observes outputs)
//   modport slave  : the selector itself
// -----------------------------------------------------------------------------
interface rx_source_select_if #(
  parameter int NCHAN = 2,
  parameter int ADC_W = 14
);

  logic                     enable;
  logic                     serial_strobe;
  logic [6:0]               serial_addr;
  logic [31:0]              serial_data;
  logic                     in_strobe;
  logic [NCHAN*16-1:0]      ddc_in;
  logic [NCHAN*ADC_W-1:0]   adc_in;
  logic [NCHAN*16-1:0]      ch_out;
  logic                     out_strobe;
  logic                     burst_active;
  logic                     burst_done;
  logic [15:0]              sample_count;

  modport master (
    output enable, serial_strobe, serial_addr, serial_data,
    output in_strobe, ddc_in, adc_in,
    input  ch_out, out_strobe, burst_active, burst_done, sample_count
  );

  modport slave (
    input  enable, serial_strobe, serial_addr, serial_data,
    input  in_strobe, ddc_in, adc_in,
    output ch_out, out_strobe, burst_active, burst_done, sample_count
  );

endinterface

// File: rtl/rx_source_select_prbs15.sv
// -----------------------------------------------------------------------------
// rx_prbs15
//   One 15-bit PRBS generator (x^15 + x^14 + 1). Loads `seed` on reset or
//   whenever `load` is high; otherwise steps once per cycle with `advance`.
//   Ports: clock, reset (sync, active-high), load, advance, seed[14:0],
//          q[14:0] (current state).
// -----------------------------------------------------------------------------
module rx_prbs15
  import rx_source_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  input  logic [14:0] seed,
  output logic [14:0] q
);

  logic [14:0] state_q;
  logic [14:0] state_d;

  // Reload wins over advance so a restart is always clean.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (advance) begin
      state_d = prbs15_next(state_q);
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign q = state_q;

endmodule

// File: rtl/rx_source_select.sv
// -----------------------------------------------------------------------------
// rx_source_select
//   Per-channel sample-source selector for NCHAN receive paths, with an armed
//   burst-capture mode that emits exactly BURST_LEN strobes and then stops.
//   Lives in the adcclk domain between rx_chain/adc_interface and rx_buffer.
//
//   Ports:
//     clock       adcclk, the only clock
//     reset       synchronous, active-high
//     bus         rx_source_select_if.slave:
//                   enable, serial_strobe/addr/data (settings writes),
//                   in_strobe, ddc_in, adc_in (sample inputs),
//                   ch_out, out_strobe (registered selected samples),
//                   burst_active, burst_done, sample_count (burst status)
//
//   Registers (address = BASE + offset):
//     MODE  [2:0] src, [3] burst enable, [4] arm (pulse, not stored)
//     LEN   [15:0] burst length
//     CONST [15:0] constant sample driven on every channel
// -----------------------------------------------------------------------------
module rx_source_select
  import rx_source_pkg::*;
#(
  parameter int         NCHAN = 2,
  parameter int         ADC_W = 14,
  parameter logic [6:0] BASE  = 7'd80
) (
  input  logic               clock,
  input  logic               reset,
  rx_source_select_if.slave  bus
);

  localparam logic [15:0] CNT_STEP = 16'(NCHAN);

  // ---------------------------------------------------------------------------
  // Settings bus decode
  // ---------------------------------------------------------------------------
  logic wr_mode;
  logic wr_len;
  logic wr_const;

  assign wr_mode  = bus.serial_strobe && (bus.serial_addr == BASE + OFF_MODE);
  assign wr_len   = bus.serial_strobe && (bus.serial_addr == BASE + OFF_LEN);
  assign wr_const = bus.serial_strobe && (bus.serial_addr == BASE + OFF_CONST);

  // Only the low half-word of serial_data carries any register field.
  logic unused_data_hi;
  assign unused_data_hi = ^bus.serial_data[31:16];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [MODE_STORED_W-1:0] mode_q;
  logic [15:0]              len_q;
  logic [15:0]              const_q;
  burst_state_e             state_q, state_d;
  logic [15:0]              count_q, count_d;
  logic [15:0]              cnt_q;
  logic [NCHAN*16-1:0]      ch_out_q;
  logic                     out_strobe_q;

  src_e src_cur;
  src_e src_wr;
  logic burst_mode;
  logic arm_wr;
  logic src_chg;
  logic restart;
  logic emit;
  logic [15:0] count_inc;

  assign src_cur    = decode_src(mode_q[MODE_SRC_LSB +: MODE_SRC_W]);
  assign src_wr     = decode_src(bus.serial_data[MODE_SRC_LSB +: MODE_SRC_W]);
  assign burst_mode = mode_q[MODE_BURST_BIT];

  // Arm only means something when the same write also enables burst mode;
  // any other MODE write drops the FSM back to IDLE.
  assign arm_wr  = wr_mode && bus.serial_data[MODE_ARM_BIT]
                           && bus.serial_data[MODE_BURST_BIT];
  assign src_chg = wr_mode && (src_wr != src_cur);

  // Counter and LFSRs restart while disabled, on arm, and on a source change,
  // so every burst and every freshly selected source starts from known state.
  assign restart = !bus.enable || arm_wr || src_chg;

  assign count_inc = count_q + 16'd1;

  // ---------------------------------------------------------------------------
  // Burst FSM: next state, sample counter and emit decision
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    emit    = 1'b0;

    // Sample-driven progress happens only while enabled; the strobe is judged
    // against the configuration in force before any same-cycle write.
    if (bus.enable && bus.in_strobe) begin
      if (!burst_mode) begin
        emit = 1'b1;
      end else begin
        case (state_q)
          ST_ARMED, ST_RUN: begin
            if (state_q == ST_ARMED && len_q == 16'd0) begin
              // Zero-length burst completes without emitting anything.
              state_d = ST_DONE;
            end else begin
              emit    = 1'b1;
              count_d = count_inc;
              // >= keeps a BURST_LEN lowered mid-run from running forever.
              state_d = (count_inc >= len_q) ? ST_DONE : ST_RUN;
            end
          end
          default: ;
        endcase
      end
    end

    // A MODE write overrides whatever the strobe would have done.
    if (wr_mode) begin
      if (arm_wr) begin
        state_d = ST_ARMED;
        count_d = '0;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel PRBS generators
  // ---------------------------------------------------------------------------
  logic [14:0] prbs_q    [NCHAN];
  logic [15:0] adc_just  [NCHAN];

  for (genvar g = 0; g < NCHAN; g++) begin : g_ch
    rx_prbs15 u_prbs (
      .clock   (clock),
      .reset   (reset),
      .load    (restart),
      .advance (emit),
      .seed    (PRBS_SEED_BASE + 15'(g)),
      .q       (prbs_q[g])
    );

    // Raw ADC word, left-justified into 16 bits.
    assign adc_just[g] = 16'(bus.adc_in[g*ADC_W +: ADC_W]) << (16 - ADC_W);
  end

  // ---------------------------------------------------------------------------
  // Source mux
  // ---------------------------------------------------------------------------
  logic [NCHAN*16-1:0] ch_sel;

  always_comb begin
    ch_sel = '0;
    for (int k = 0; k < NCHAN; k++) begin
      case (src_cur)
        SRC_CNT:   ch_sel[k*16 +: 16] = cnt_q + 16'(k);
        SRC_ADC:   ch_sel[k*16 +: 16] = adc_just[k];
        SRC_CONST: ch_sel[k*16 +: 16] = const_q;
        // The emitted PRBS word is the state after this strobe's advance.
        SRC_PRBS:  ch_sel[k*16 +: 16] = {1'b0, prbs15_next(prbs_q[k])};
        default:   ch_sel[k*16 +: 16] = bus.ddc_in[k*16 +: 16];
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q       <= '0;
      len_q        <= '0;
      const_q      <= '0;
      state_q      <= ST_IDLE;
      count_q      <= '0;
      cnt_q        <= '0;
      ch_out_q     <= '0;
      out_strobe_q <= 1'b0;
    end else begin
      if (wr_mode) begin
        mode_q <= bus.serial_data[MODE_STORED_W-1:0];
      end
      if (wr_len) begin
        len_q <= bus.serial_data[15:0];
      end
      if (wr_const) begin
        const_q <= bus.serial_data[15:0];
      end

      state_q      <= state_d;
      count_q      <= count_d;
      out_strobe_q <= emit;

      // ch_out holds its last value between strobes.
      if (emit) begin
        ch_out_q <= ch_sel;
      end

      if (restart) begin
        cnt_q <= '0;
      end else if (emit) begin
        cnt_q <= cnt_q + CNT_STEP;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.ch_out       = ch_out_q;
  assign bus.out_strobe   = out_strobe_q;
  assign bus.burst_active = (state_q == ST_ARMED) || (state_q == ST_RUN);
  assign bus.burst_done   = (state_q == ST_DONE);
  assign bus.sample_count = count_q;

endmodule
